// File: rtl/mp_adder_seq.sv
// Limb-serial multi-precision adder/subtractor.
// Processes one W-bit limb per cycle, LSB limb first, and ripples the carry
// through a register. sum_o/cout_o change only when an operation completes.
`timescale 1ns / 1ps

module mp_adder_seq #(
  parameter int unsigned N = 1024,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int unsigned LIMBS = N / W;
  localparam int unsigned KW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [KW-1:0] KLast = KW'(LIMBS - 1);

  if ((W < 1) || (N < W) || ((N % W) != 0)) begin : g_param_check
    $error("mp_adder_seq: N must be a non-zero multiple of W");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          done_q, done_d;
  logic [KW-1:0] k_q, k_d;

  logic [W-1:0]  b_limb;
  logic [W:0]    limb_sum;
  logic [N-1:0]  res_next;

  // Subtraction is a + ~b + ~borrow; the carry register holds the inverted borrow.
  assign b_limb   = sub_q ? ~b_q[W-1:0] : b_q[W-1:0];
  assign limb_sum = {1'b0, a_q[W-1:0]} + {1'b0, b_limb} + {{W{1'b0}}, carry_q};

  // New limb enters at the top of the partial result; after LIMBS shifts it is aligned.
  if (LIMBS == 1) begin : g_res_one
    assign res_next = limb_sum[W-1:0];
  end else begin : g_res_many
    assign res_next = {limb_sum[W-1:0], res_q[N-1:W]};
  end

  // Next-state, datapath update and outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    k_d     = k_q;
    busy_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sub_d   = sub_i;
          carry_d = sub_i ? ~cin_i : cin_i;
          res_d   = '0;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy_o  = 1'b1;
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        res_d   = res_next;
        carry_d = limb_sum[W];
        k_d     = k_q + KW'(1);
        if (k_q == KLast) begin
          sum_d   = res_next;
          cout_d  = sub_q ? ~limb_sum[W] : limb_sum[W];
          done_d  = 1'b1;
          k_d     = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      k_q     <= k_d;
    end
  end

  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Bench for mp_adder_seq: three instances (64/16, 1024/32, 32/32) share stimulus.
// Each instance has a cycle model and a scoreboard queue of expected results.
`timescale 1ns / 1ps

module tb_mp_adder_seq;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic          cin = 1'b0;
  logic [1023:0] a = '0;
  logic [1023:0] b = '0;

  logic [2:0]             busy_w;
  logic [2:0]             done_w;
  logic [2:0]             cout_w;
  logic [2:0][1023:0]     sum_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1024:0] got, input logic [1024:0] exp);
    logic [1024:0] gs, es;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      for (int i = 0; i < 17; i++) begin
        gs = got >> (64 * i);
        es = exp >> (64 * i);
        if (gs[63:0] !== es[63:0]) begin
          $display("FAIL %s: got[%0d+:64]=%h required %h", tag, 64 * i, gs[63:0], es[63:0]);
          break;
        end
      end
    end
  endtask

  // Reference: {cout, sum} of a +/- b +/- cin at width n, cout placed at bit 1024.
  function automatic logic [1024:0] ref_val(input logic [1023:0] av, input logic [1023:0] bv,
                                            input logic ci, input logic su, input int n);
    logic [1025:0] mask, am, bm, r;
    logic          c;
    mask = (1026'(1) << n) - 1026'(1);
    am   = {2'b00, av} & mask;
    bm   = {2'b00, bv} & mask;
    if (!su) begin
      r = am + bm + 1026'(ci);
      c = r[n];
    end else begin
      r = am - bm - 1026'(ci);
      c = (am < (bm + 1026'(ci)));
    end
    r = r & mask;
    return {c, r[1023:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NN = (g == 0) ? 64 : ((g == 1) ? 1024 : 32);
    localparam int WW = (g == 0) ? 16 : 32;
    localparam int LL = NN / WW;

    logic [NN-1:0] sum_l;
    int            mcnt = 0;
    bit            exp_done = 1'b0;
    logic [NN-1:0] exp_sum = '0;
    logic          exp_cout = 1'b0;
    logic [1024:0] q[$];

    mp_adder_seq #(.N(NN), .W(WW)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(start),
      .sub_i  (sub),
      .a_i    (a[NN-1:0]),
      .b_i    (b[NN-1:0]),
      .cin_i  (cin),
      .busy_o (busy_w[g]),
      .done_o (done_w[g]),
      .sum_o  (sum_l),
      .cout_o (cout_w[g])
    );

    assign sum_w[g] = 1024'(sum_l);

    // Cycle model: push expected at acceptance, pop into held outputs at completion.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mcnt     <= 0;
        exp_done <= 1'b0;
        exp_sum  <= '0;
        exp_cout <= 1'b0;
        q.delete();
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          exp_sum  <= q[0][NN-1:0];
          exp_cout <= q[0][1024];
          void'(q.pop_front());
          exp_done <= 1'b1;
        end else begin
          exp_done <= 1'b0;
        end
      end else begin
        exp_done <= 1'b0;
        if (start) begin
          q.push_back(ref_val(a, b, cin, sub, NN));
          mcnt <= LL;
        end
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        check($sformatf("busy_n%0d", NN), 1025'(busy_w[g]), 1025'(mcnt != 0));
        check($sformatf("done_n%0d", NN), 1025'(done_w[g]), 1025'(exp_done));
        check($sformatf("sum_n%0d", NN), 1025'(sum_l), 1025'(exp_sum));
        check($sformatf("cout_n%0d", NN), 1025'(cout_w[g]), 1025'(exp_cout));
      end
    end
  end

  // Single operation on the 64-bit instance; counts edges to done and cycles with busy.
  task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                        input logic su, output int lat, output int bcnt);
    @(negedge clk);
    a = 1024'(av);
    b = 1024'(bv);
    cin = ci;
    sub = su;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (lat < 64) begin
      if (busy_w[0]) bcnt++;
      @(posedge clk);
      #1;
      lat++;
      if (done_w[0]) break;
    end
  endtask

  typedef struct {
    logic [63:0] av;
    logic [63:0] bv;
    logic        ci;
    logic        su;
    logic [63:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[4] = '{
    '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0},
    '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1},
    '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1},
    '{64'd7, 64'd5, 1'b1, 1'b1, 64'h1, 1'b0}
  };

  initial begin
    int lat, bcnt, guard;

    repeat (2) @(negedge clk);
    check("rst_busy", 1025'(busy_w), 1025'(0));
    check("rst_done", 1025'(done_w), 1025'(0));
    check("rst_sum", 1025'(sum_w[0]), 1025'(0));
    check("rst_cout", 1025'(cout_w), 1025'(0));
    rst_n = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].av, vecs[i].bv, vecs[i].ci, vecs[i].su, lat, bcnt);
      check($sformatf("vec%0d_lat", i), 1025'(lat), 1025'(4));
      check($sformatf("vec%0d_busy_cycles", i), 1025'(bcnt), 1025'(4));
      check($sformatf("vec%0d_sum", i), 1025'(sum_w[0]), 1025'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 1025'(cout_w[0]), 1025'(vecs[i].c));
      @(posedge clk);
      #1 check($sformatf("vec%0d_done_pulse", i), 1025'(done_w[0]), 1025'(0));
    end

    // Start held through the run, operands changed mid-run, restart in done cycle.
    @(negedge clk);
    a = 1024'(64'h1234_5678_9ABC_DEF0);
    b = 1024'(64'h0FED_CBA9_8765_4321);
    cin = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 1024'(64'hFFFF_0000_FFFF_0000);
    b = 1024'(64'h0001_FFFF_0001_0000);
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_w[0]) break;
    end
    check("hs_lat1", 1025'(lat), 1025'(4));
    check("hs_sum1", 1025'(sum_w[0]), 1025'(64'h2222_2222_2222_2211));
    check("hs_cout1", 1025'(cout_w[0]), 1025'(0));
    @(posedge clk);
    #1 start = 1'b0;
    check("hs_single_pulse", 1025'(done_w[0]), 1025'(0));
    check("hs_restart_busy", 1025'(busy_w[0]), 1025'(1));
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_w[0]) break;
    end
    check("hs_lat2", 1025'(lat), 1025'(4));
    check("hs_sum2", 1025'(sum_w[0]), 1025'(64'h0001_0000_0000_0000));
    check("hs_cout2", 1025'(cout_w[0]), 1025'(1));

    // Asynchronous reset two cycles into an operation.
    @(negedge clk);
    a = 1024'(64'h0000_0000_FFFF_FFFF);
    b = 1024'(64'h1);
    cin = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_busy", 1025'(busy_w), 1025'(0));
    check("mrst_sum", 1025'(sum_w[0]), 1025'(0));
    check("mrst_cout", 1025'(cout_w), 1025'(0));
    repeat (3) begin
      @(negedge clk);
      check("mrst_no_done", 1025'(done_w), 1025'(0));
    end
    rst_n = 1'b1;
    run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, bcnt);
    check("mrst_after_lat", 1025'(lat), 1025'(4));
    check("mrst_after_sum", 1025'(sum_w[0]), 1025'(64'h0000_0001_0000_0000));

    // Let every instance go idle before the random run.
    guard = 0;
    while ((busy_w != 3'b000) && (guard < 100)) begin
      @(negedge clk);
      guard++;
    end
    check("pre_rand_idle", 1025'(busy_w), 1025'(0));

    // Random regression; the scoreboards check every instance each cycle.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      for (int j = 0; j < 32; j++) begin
        a[32*j +: 32] = $urandom;
        b[32*j +: 32] = $urandom;
      end
      if ($urandom_range(0, 7) == 0) b = ~a;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while ((busy_w != 3'b000) && (guard < 100)) begin
        @(negedge clk);
        guard++;
      end
      check("rand_idle", 1025'(busy_w), 1025'(0));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_adder_seq.md
Name: mp_adder_seq

Overview:
- Multi-cycle, limb-serial multi-precision adder/subtractor for the RSA datapath in the EX-stage ALU.
- Adds or subtracts two N-bit operands W bits per cycle, rippling the carry through a register between limbs.
- Wide modular-arithmetic operands (e.g. 1024-bit) therefore cost one W-bit adder instead of a full-width combinational chain.
- Start/done handshake; the result and carry/borrow are held stable until the next operation.

Parameters:
- N, 1024, operand and result width in bits; must be an integer multiple of W.
- W, 32, limb width in bits processed per cycle.
- LIMBS, N/W, derived local parameter; number of cycles per operation; must be at least 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin (cin acts as borrow-in). Captured with start.
- a  input  N  first operand; captured with start.
- b  input  N  second operand; captured with start.
- cin  input  1  carry-in (add) or borrow-in (sub); captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  N  result, mod 2^N.
- cout  output  1  carry-out (add) or borrow-out (sub).

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, partial-result and limb-counter registers cleared.
- FSM states are IDLE and RUN.
- IDLE to RUN:
  - Triggered when start=1 at a rising edge.
  - That edge latches a, b and sub.
  - It initialises the carry register to (sub ? ~cin : cin) and the limb index k to 0.
  - It sets busy=1.
- RUN, one limb per edge (k = 0..LIMBS-1, LSB limb first):
  - Compute {c', r_k} = a_k + (sub ? ~b_k : b_k) + c (W+1 bits).
  - Store r_k into the partial-result register, update the carry register to c', and increment k.
- RUN to IDLE, at the edge that processes k = LIMBS-1:
  - sum <= full partial result, including limb LIMBS-1.
  - cout <= (sub ? ~c' : c').
  - done <= 1 for exactly one cycle; busy <= 0.
- Latency: start sampled at edge t0; done=1 and sum/cout valid after edge t0+LIMBS; busy is high for exactly LIMBS cycles.
- sum and cout update only on completion; intermediate limbs are never visible on sum. Outputs hold until the next completion or reset.
- start while busy: ignored. The operation in flight is unaffected, and inputs may change freely after the start edge.
- start in the cycle done=1: accepted, since the FSM is already IDLE. done stays a single-cycle pulse and a new operation begins.
- LIMBS=1: the block degenerates to a registered single-cycle add, with done one edge after start.
- Arithmetic rules:
  - Add: {cout, sum} = a + b + cin, exact modulo 2^(N+1).
  - Sub: sum = (a - b - cin) mod 2^N, and cout=1 iff a < b + cin (borrow).
- Reset mid-operation: aborts immediately, and all outputs return to reset values. No done is produced for the aborted operation.
- Elaboration check: N % W != 0 or W < 1 triggers a $error.

Test Plan:
- All scenarios use N=64, W=16, LIMBS=4 unless stated.
- Add with cross-limb carry:
  - Stimulus: a=64'h0000_0000_FFFF_FFFF, b=1, cin=0, sub=0.
  - Required: done exactly 4 cycles after start; sum=64'h0000_0001_0000_0000, cout=0; busy high for 4 cycles.
- Full-width overflow:
  - Stimulus: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0.
  - Required: sum=0, cout=1.
- Subtract with borrow:
  - Stimulus 1: a=5, b=7, cin=0, sub=1. Required: sum=64'hFFFF_FFFF_FFFF_FFFE, cout=1.
  - Stimulus 2: a=7, b=5, cin=1, sub=1. Required: sum=1, cout=0.
- Handshake corners:
  - Stimulus: start held high through the run with a, b changed mid-run; a second start in the done cycle.
  - Required: first result reflects only the originally latched operands; second operation completes 4 cycles later with one done pulse per operation.
- Reset mid-op:
  - Stimulus: assert rst_n=0 two cycles after start, asynchronously between edges.
  - Required: busy=0, sum=0, cout=0 immediately; no done pulse; a subsequent operation completes correctly.
- Random regression:
  - Stimulus: 1000 random operations with random sub and cin, at N=64/W=16, N=1024/W=32 and N=32/W=32.
  - Required: results match the reference model ({cout,sum} = a±b±cin), with latency equal to LIMBS each time.
